// File: rtl/prbs_chk.sv
// Parallel PRBS checker: self-synchronises an LFSR predictor to SIZE-bit words, locks, then counts bit errors.
// Outputs are registered and reflect the sampled word one cycle later; din_valid=0 freezes all state.
module prbs_chk #(
  parameter int                SIZE       = 8,
  parameter int                LENGTH     = 7,
  parameter logic [LENGTH-1:0] PRIMPOLY   = 7'b1100000,
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 4,
  parameter int                CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE-1:0]            din,
  input  logic                       din_valid,
  input  logic                       clear_cnt,
  output logic                       locked,
  output logic                       err_word,
  output logic [$clog2(SIZE+1)-1:0]  err_bits,
  output logic [CNT_W-1:0]           err_cnt,
  output logic                       sync_loss
);

  localparam int EBW = $clog2(SIZE + 1);
  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int BCW = $clog2(UNLOCK_CNT + 1);
  localparam int SW  = CNT_W + 1;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  // State bit 0 is the oldest stream bit; taps are numbered from the MSB of PRIMPOLY.
  function automatic logic [SIZE-1:0] predict(input logic [LENGTH-1:0] st);
    logic [LENGTH-1:0] s;
    logic              nb;
    logic [SIZE-1:0]   w;
    s = st;
    w = '0;
    for (int c = 0; c < SIZE; c++) begin
      nb = 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        if (PRIMPOLY[LENGTH-1-i]) nb = nb ^ s[i];
      end
      w[c] = nb;
      s    = {nb, s[LENGTH-1:1]};
    end
    return w;
  endfunction

  function automatic logic [EBW-1:0] popcount(input logic [SIZE-1:0] v);
    logic [EBW-1:0] n;
    n = '0;
    for (int c = 0; c < SIZE; c++) n = n + EBW'(v[c]);
    return n;
  endfunction

  state_t            state, state_d;
  logic [LENGTH-1:0] pred, pred_d, seed, pred_next;
  logic [SIZE-1:0]   expw, mism;
  logic [EBW-1:0]    nbits, err_bits_d;
  logic [MCW-1:0]    match_cnt, match_d;
  logic [BCW-1:0]    bad_cnt, bad_d;
  logic [SW-1:0]     sum;
  logic [CNT_W-1:0]  cnt_sat, cnt_d;
  logic              err_word_d, sync_d, locked_d;

  assign seed      = din[SIZE-1 -: LENGTH];
  assign expw      = predict(pred);
  assign pred_next = expw[SIZE-1 -: LENGTH];
  assign mism      = din ^ expw;
  assign nbits     = popcount(mism);
  assign sum       = {1'b0, err_cnt} + SW'(nbits);
  assign cnt_sat   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  always_comb begin
    state_d    = state;
    pred_d     = pred;
    match_d    = match_cnt;
    bad_d      = bad_cnt;
    err_word_d = 1'b0;
    err_bits_d = '0;
    sync_d     = 1'b0;
    cnt_d      = err_cnt;
    if (din_valid) begin
      case (state)
        HUNT: begin
          pred_d = seed;
          if (seed != '0) begin
            state_d = CHECK;
            match_d = '0;
          end
        end
        CHECK: begin
          if (mism == '0) begin
            pred_d  = pred_next;
            match_d = match_cnt + 1'b1;
            if (match_cnt == MCW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            pred_d  = seed;
            match_d = '0;
            if (seed == '0) state_d = HUNT;
          end
        end
        LOCKED: begin
          // Never reseeded here, so a lone flipped bit is counted exactly once.
          pred_d = pred_next;
          if (mism != '0) begin
            err_word_d = 1'b1;
            err_bits_d = nbits;
            cnt_d      = cnt_sat;
            bad_d      = bad_cnt + 1'b1;
            if (bad_cnt == BCW'(UNLOCK_CNT - 1)) begin
              state_d = HUNT;
              sync_d  = 1'b1;
              bad_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clear_cnt) cnt_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err_word  <= 1'b0;
      err_bits  <= '0;
      err_cnt   <= '0;
      sync_loss <= 1'b0;
    end else begin
      state     <= state_d;
      pred      <= pred_d;
      match_cnt <= match_d;
      bad_cnt   <= bad_d;
      locked    <= locked_d;
      err_word  <= err_word_d;
      err_bits  <= err_bits_d;
      err_cnt   <= cnt_d;
      sync_loss <= sync_d;
    end
  end

endmodule

// File: tb/tb_prbs_chk.sv
// Bench for prbs_chk: table-driven lock/error vectors, corner sequences and a randomized run against a stream-level model.
module tb_prbs_chk;

  localparam int SIZE = 8;
  localparam int LEN = 7;
  localparam logic [LEN-1:0] POLY = 7'b1100000;
  localparam int LOCKN = 4;
  localparam int UNLOCKN = 4;
  localparam int NGOLD = 127;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] din;
  logic din_valid, clear_cnt;
  logic locked, err_word, sync_loss;
  logic [3:0] err_bits;
  logic [31:0] err_cnt;
  logic locked_s, err_word_s, sync_loss_s;
  logic [3:0] err_bits_s, err_cnt_s;

  always #5 clk = ~clk;

  prbs_chk #(.SIZE(8), .LENGTH(7), .PRIMPOLY(7'b1100000), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err_word(err_word), .err_bits(err_bits), .err_cnt(err_cnt), .sync_loss(sync_loss));

  prbs_chk #(.SIZE(8), .LENGTH(7), .PRIMPOLY(7'b1100000), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked_s), .err_word(err_word_s), .err_bits(err_bits_s), .err_cnt(err_cnt_s), .sync_loss(sync_loss_s));

  int nchk = 0;
  int nerr = 0;

  // Golden stream: serial recurrence, then packed LSB-first into words.
  bit xs[NGOLD*SIZE];
  logic [7:0] gold[NGOLD];
  int gidx = 0;

  // Reference model: history of the last LEN stream bits plus mode/counters.
  int m_mode;
  bit hist[$];
  int m_mcnt, m_bcnt;
  longint m_cnt;
  int m_cnt4;
  bit e_locked, e_ew, e_sl;
  int e_eb;

  typedef struct {
    logic [7:0] flip;
    bit vld;
    bit clr;
    bit lk;
    bit ew;
    int eb;
    int cnt;
    bit sl;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_gold(output logic [7:0] w);
    w = gold[gidx % NGOLD];
    gidx++;
  endtask

  task automatic model_reset();
    m_mode = 0;
    hist = {};
    for (int i = 0; i < LEN; i++) hist.push_back(1'b0);
    m_mcnt = 0; m_bcnt = 0; m_cnt = 0; m_cnt4 = 0;
    e_locked = 0; e_ew = 0; e_sl = 0; e_eb = 0;
  endtask

  task automatic seed_hist(input logic [7:0] d);
    hist = {};
    for (int c = SIZE - LEN; c < SIZE; c++) hist.push_back(d[c]);
  endtask

  task automatic model_step(input logic [7:0] d, input bit v, input bit c);
    bit q[$];
    logic [7:0] p;
    bit b;
    e_ew = 0; e_eb = 0; e_sl = 0;
    if (v) begin
      q = hist;
      p = '0;
      for (int k = 0; k < SIZE; k++) begin
        b = 0;
        for (int i = 0; i < LEN; i++) if (POLY[LEN-1-i]) b ^= q[i];
        p[k] = b;
        q.push_back(b);
        void'(q.pop_front());
      end
      if (m_mode == 0) begin
        seed_hist(d);
        if (d[SIZE-1 -: LEN] != 0) begin m_mode = 1; m_mcnt = 0; end
      end else if (m_mode == 1) begin
        if (d == p) begin
          hist = q;
          m_mcnt++;
          if (m_mcnt == LOCKN) begin m_mode = 2; m_bcnt = 0; end
        end else begin
          m_mcnt = 0;
          seed_hist(d);
          if (d[SIZE-1 -: LEN] == 0) m_mode = 0;
        end
      end else begin
        hist = q;
        if (d != p) begin
          e_ew = 1;
          e_eb = $countones(d ^ p);
          m_cnt = (m_cnt + e_eb > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + e_eb;
          m_cnt4 = (m_cnt4 + e_eb > 15) ? 15 : m_cnt4 + e_eb;
          m_bcnt++;
          if (m_bcnt == UNLOCKN) begin m_mode = 0; e_sl = 1; m_bcnt = 0; end
        end else begin
          m_bcnt = 0;
        end
      end
    end
    if (c) begin m_cnt = 0; m_cnt4 = 0; end
    e_locked = (m_mode == 2);
  endtask

  // Called on a negedge; returns on the next negedge after checking the post-edge outputs.
  task automatic step(input logic [7:0] d, input bit v, input bit c);
    din = d; din_valid = v; clear_cnt = c;
    @(posedge clk);
    #1;
    model_step(d, v, c);
    chk("locked", locked, e_locked);
    chk("err_word", err_word, e_ew);
    chk("err_bits", err_bits, e_eb);
    chk("err_cnt", err_cnt, m_cnt);
    chk("sync_loss", sync_loss, e_sl);
    chk("locked_small", locked_s, e_locked);
    chk("err_cnt_small", err_cnt_s, m_cnt4);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    din_valid = 1'b0;
    clear_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w, d;
    bit b, v, c;
    int vc, ewc, burst, r;

    reset = 1'b0; din = '0; din_valid = 1'b0; clear_cnt = 1'b0;
    for (int n = 0; n < NGOLD * SIZE; n++) begin
      if (n < LEN) xs[n] = 1'b1;
      else begin
        b = 0;
        for (int i = 0; i < LEN; i++) if (POLY[LEN-1-i]) b ^= xs[n-LEN+i];
        xs[n] = b;
      end
    end
    for (int j = 0; j < NGOLD; j++)
      for (int k = 0; k < SIZE; k++) gold[j][k] = xs[j*SIZE+k];

    tbl[0]  = '{8'h00, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{8'h00, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{8'h00, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{8'h00, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{8'h00, 1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{8'h08, 1, 0, 1, 1, 1, 1, 0};
    tbl[6]  = '{8'h00, 1, 0, 1, 0, 0, 1, 0};
    tbl[7]  = '{8'h00, 0, 0, 1, 0, 0, 1, 0};
    tbl[8]  = '{8'hFF, 1, 0, 1, 1, 8, 9, 0};
    tbl[9]  = '{8'hFF, 1, 0, 1, 1, 8, 17, 0};
    tbl[10] = '{8'hFF, 1, 0, 1, 1, 8, 25, 0};
    tbl[11] = '{8'hFF, 1, 0, 0, 1, 8, 33, 1};
    tbl[12] = '{8'h00, 1, 0, 0, 0, 0, 33, 0};
    tbl[13] = '{8'h00, 1, 0, 0, 0, 0, 33, 0};
    tbl[14] = '{8'h00, 1, 0, 0, 0, 0, 33, 0};
    tbl[15] = '{8'h00, 1, 0, 0, 0, 0, 33, 0};
    tbl[16] = '{8'h00, 1, 0, 1, 0, 0, 33, 0};
    tbl[17] = '{8'h03, 1, 1, 1, 1, 2, 0, 0};
    tbl[18] = '{8'h00, 1, 0, 1, 0, 0, 0, 0};

    @(negedge clk);
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_err_word", err_word, 0);
    chk("rst_err_bits", err_bits, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sync_loss", sync_loss, 0);

    // Lock-up, single flip, hold on invalid, 4-word inversion, relock, clear vs error.
    gidx = 0;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].vld) begin next_gold(w); d = w ^ tbl[i].flip; end
      else d = 8'($urandom);
      step(d, tbl[i].vld, tbl[i].clr);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_err_word", i), err_word, tbl[i].ew);
      chk($sformatf("tbl%0d_err_bits", i), err_bits, tbl[i].eb);
      chk($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_sync_loss", i), sync_loss, tbl[i].sl);
    end

    // Long clean run while locked.
    ewc = 0;
    for (int i = 0; i < 2000; i++) begin
      next_gold(w);
      step(w, 1, 0);
      if (err_word) ewc++;
    end
    chk("clean_err_pulses", ewc, 0);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_locked", locked, 1);

    // Saturation of the narrow counter: 20 single-bit errors interleaved with clean words.
    next_gold(w);
    step(w, 1, 1);
    for (int k = 0; k < 20; k++) begin
      next_gold(w);
      d = w ^ (8'h01 << (k % 8));
      step(d, 1, 0);
      next_gold(w);
      step(w, 1, 0);
    end
    chk("sat_cnt_wide", err_cnt, 20);
    chk("sat_cnt_narrow", err_cnt_s, 15);
    chk("sat_locked", locked, 1);

    // Asynchronous reset while locked with an error pulse on the outputs.
    next_gold(w);
    step(w ^ 8'h10, 1, 0);
    chk("pre_reset_err_word", err_word, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_err_word", err_word, 0);
    chk("async_rst_err_bits", err_bits, 0);
    chk("async_rst_sync_loss", sync_loss, 0);
    @(negedge clk);
    do_reset();

    // All-zero input never leaves HUNT.
    for (int i = 0; i < 60; i++) step(8'h00, 1, 0);
    chk("zero_locked", locked, 0);

    // Golden stream with random gaps: lock on the 5th valid word.
    do_reset();
    vc = 0;
    for (int i = 0; i < 200 && vc < 6; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) next_gold(d); else d = 8'($urandom);
      step(d, v, 0);
      if (v) begin
        vc++;
        if (vc == 4) chk("gap_locked_after4", locked, 0);
        if (vc == 5) chk("gap_locked_after5", locked, 1);
      end
    end
    chk("gap_words_seen", vc, 6);
    chk("gap_err_cnt", err_cnt, 0);

    // Randomized errors, bursts, gaps and clears against the model.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (v) begin
        next_gold(w);
        r = $urandom_range(0, 99);
        if (burst > 0) begin d = ~w; burst--; end
        else if (r < 6) d = w ^ (8'h01 << $urandom_range(0, 7));
        else if (r < 9) d = w ^ 8'($urandom_range(1, 255));
        else if (r == 99) begin d = ~w; burst = 4; end
        else d = w;
      end else begin
        d = 8'($urandom);
      end
      step(d, v, c);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
